// File: rtl/uart_bus_master.sv
// uart_bus_master: WISHBONE master that moves bytes between an 8-entry TX FIFO (plus a
// single-byte RX holding register) and a memory-mapped UART with a data register and a
// line status register (bit 0 = receive ready, bit 5 = transmit ready).
// Optional receive path: define UART_BUS_MASTER_RX_EN to enable RXRD/RXCLR and rx_* outputs.
// Without it the block is transmit-only and rx_valid/rx_byte read as zero.
module uart_bus_master #(
  parameter logic [2:0]  OFF_DATA = 3'd0,
  parameter logic [2:0]  OFF_LSR  = 3'd1,
  parameter int unsigned TX_GAP   = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [4:2]  ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  input  logic [7:0]  tx_byte,
  input  logic        tx_push,
  output logic        tx_full,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic        rx_pop
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPoll  = 3'd1,
    StTxWr  = 3'd2,
    StRxRd  = 3'd3,
    StRxClr = 3'd4,
    StGap   = 3'd5
  } state_e;

  // A zero gap still spends one cycle in GAP so the state is never skipped.
  localparam int unsigned GapCycles = (TX_GAP < 1) ? 1 : TX_GAP;
  localparam int unsigned GapW      = (GapCycles < 2) ? 1 : $clog2(GapCycles);
  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

  state_e          r_state, w_state_d;
  logic            r_stb, w_stb_d;
  logic            r_we, w_we_d;
  logic [2:0]      r_adr, w_adr_d;
  logic [31:0]     r_dat, w_dat_d;
  logic [GapW-1:0] r_gap, w_gap_d;

  logic [7:0]      r_fifo [8];
  logic [2:0]      r_wr_ptr;
  logic [2:0]      r_rd_ptr;
  logic [3:0]      r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_fifo_empty;
  logic            w_rs;
  logic            w_ts;
  logic            w_rx_cap;
  logic            w_rx_valid;
  logic            w_unused;

  assign w_ts         = DAT_I[5];
  assign w_fifo_empty = (r_count == 4'd0);
  assign tx_full      = (r_count == 4'd8);
  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign w_push       = tx_push & (~tx_full | w_pop);

  assign STB_O = r_stb;
  assign WE_O  = r_we;
  assign ADR_O = r_adr;
  assign DAT_O = r_dat;

  // Next-state and bus-output logic; bus signals are registered so each access starts clean.
  always_comb begin
    w_state_d = r_state;
    w_stb_d   = r_stb;
    w_we_d    = r_we;
    w_adr_d   = r_adr;
    w_dat_d   = r_dat;
    w_gap_d   = r_gap;
    w_pop     = 1'b0;
    w_rx_cap  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Launch the LSR read now so POLL begins with STB_O already high.
        w_state_d = StPoll;
        w_stb_d   = 1'b1;
        w_we_d    = 1'b0;
        w_adr_d   = OFF_LSR;
        w_dat_d   = '0;
      end
      StPoll: begin
        if (!r_stb) begin
          w_stb_d = 1'b1;
          w_we_d  = 1'b0;
          w_adr_d = OFF_LSR;
          w_dat_d = '0;
        end else if (ACK_I) begin
          {w_stb_d, w_we_d, w_adr_d, w_dat_d} = '0;
          if (w_rs && !w_rx_valid) begin
            w_state_d = StRxRd;
          end else if (w_ts && !w_fifo_empty) begin
            w_state_d = StTxWr;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StTxWr: begin
        // First cycle here has STB_O low, giving the idle cycle after the poll.
        if (!r_stb) begin
          w_stb_d = 1'b1;
          w_we_d  = 1'b1;
          w_adr_d = OFF_DATA;
          w_dat_d = {24'b0, r_fifo[r_rd_ptr]};
        end else if (ACK_I) begin
          {w_stb_d, w_we_d, w_adr_d, w_dat_d} = '0;
          w_pop     = 1'b1;
          w_gap_d   = '0;
          w_state_d = StGap;
        end
      end
      StRxRd: begin
        if (!r_stb) begin
          w_stb_d = 1'b1;
          w_we_d  = 1'b0;
          w_adr_d = OFF_DATA;
          w_dat_d = '0;
        end else if (ACK_I) begin
          {w_stb_d, w_we_d, w_adr_d, w_dat_d} = '0;
          w_rx_cap  = 1'b1;
          w_state_d = StRxClr;
        end
      end
      StRxClr: begin
        // Any write to the LSR clears the slave's receive flag.
        if (!r_stb) begin
          w_stb_d = 1'b1;
          w_we_d  = 1'b1;
          w_adr_d = OFF_LSR;
          w_dat_d = '0;
        end else if (ACK_I) begin
          {w_stb_d, w_we_d, w_adr_d, w_dat_d} = '0;
          w_state_d = StIdle;
        end
      end
      StGap: begin
        // Let the slave's transmit-ready flag fall before polling again.
        if (r_gap == GapLast) begin
          w_state_d = StIdle;
        end else begin
          w_gap_d = r_gap + 1'b1;
        end
      end
      default: begin
        {w_stb_d, w_we_d, w_adr_d, w_dat_d} = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= StIdle;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_d;
      r_stb   <= w_stb_d;
      r_we    <= w_we_d;
      r_adr   <= w_adr_d;
      r_dat   <= w_dat_d;
      r_gap   <= w_gap_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 3'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 3'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; a full-FIFO push overwrites the head only as it is popped.
  always_ff @(posedge CLK_I) begin
    if (!RST_I && w_push) begin
      r_fifo[r_wr_ptr] <= tx_byte;
    end
  end

`ifdef UART_BUS_MASTER_RX_EN
  logic       r_rx_valid;
  logic [7:0] r_rx_byte;

  // Receive holding register; a capture only happens while it is empty.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_rx_valid <= 1'b0;
      r_rx_byte  <= '0;
    end else if (w_rx_cap) begin
      r_rx_valid <= 1'b1;
      r_rx_byte  <= DAT_I[7:0];
    end else if (rx_pop) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign w_rs       = DAT_I[0];
  assign w_rx_valid = r_rx_valid;
  assign rx_valid   = r_rx_valid;
  assign rx_byte    = r_rx_byte;
  assign w_unused   = ^DAT_I[31:8];
`else
  assign w_rs       = 1'b0;
  assign w_rx_valid = 1'b0;
  assign rx_valid   = 1'b0;
  assign rx_byte    = 8'h00;
  assign w_unused   = ^{DAT_I[31:6], DAT_I[4:0], rx_pop, w_rx_cap};
`endif

endmodule

// File: tb/tb_uart_bus_master.sv
// Testbench for uart_bus_master: a UART slave model answers the bus, a queue-based model of
// the FIFO and receive register is compared every cycle, and directed scenarios pin
// hand-computed values. Receive scenarios follow UART_BUS_MASTER_RX_EN like the design.
module tb_uart_bus_master;

  localparam logic [2:0]  OffData = 3'd0;
  localparam logic [2:0]  OffLsr  = 3'd1;
  localparam int unsigned TxGap   = 2;

  localparam int CntDataWr = 0;
  localparam int CntDataRd = 1;
  localparam int CntLsrWr  = 2;

  logic        clk;
  logic        RST_I;
  logic [4:2]  ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;
  logic [7:0]  tx_byte;
  logic        tx_push;
  logic        tx_full;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_pop;

  uart_bus_master #(
    .OFF_DATA (OffData),
    .OFF_LSR  (OffLsr),
    .TX_GAP   (TxGap)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (RST_I),
    .ADR_O    (ADR_O),
    .DAT_O    (DAT_O),
    .DAT_I    (DAT_I),
    .STB_O    (STB_O),
    .WE_O     (WE_O),
    .ACK_I    (ACK_I),
    .tx_byte  (tx_byte),
    .tx_push  (tx_push),
    .tx_full  (tx_full),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- UART slave model ----------------
  logic [31:0] lsr_reg;
  logic [31:0] data_reg;
  int          stall_n;
  int          sl_wait = 0;

  always begin
    @(posedge clk);
    #1;
    if (STB_O === 1'b1) begin
      if (sl_wait >= stall_n) begin
        ACK_I   = 1'b1;
        sl_wait = 0;
        if (WE_O) begin
          if (ADR_O == OffLsr) lsr_reg[0] = 1'b0;
          DAT_I = 32'h0;
        end else begin
          DAT_I = (ADR_O == OffLsr) ? lsr_reg : data_reg;
        end
      end else begin
        ACK_I = 1'b0;
        sl_wait++;
      end
    end else begin
      ACK_I   = 1'b0;
      DAT_I   = 32'h0;
      sl_wait = 0;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [7:0]  m_q[$];
  logic        m_rx_valid;
  logic [7:0]  m_rx_byte;
  bit          armed = 0;
  bit          prev_acc, prev_wait;
  logic        prev_we;
  logic [2:0]  prev_adr;
  logic [31:0] prev_dat;
  int          gap_left;
  int          n_data_wr = 0;
  int          n_data_rd = 0;
  int          n_lsr_wr  = 0;
  logic [31:0] wr_words[$];
  logic [3:0]  acc_log[$];

  always @(negedge clk) begin
    bit acc, pop, accept;
    if (armed) begin
      check("tx_full", tx_full, m_q.size() == 8);
      check("rx_valid", rx_valid, m_rx_valid);
      check("rx_byte", rx_byte, m_rx_byte);
      if (prev_acc) check("stb_idle_between", STB_O, 1'b0);
      if (prev_wait) begin
        check("stb_held", STB_O, 1'b1);
        check("bus_stable", {WE_O, ADR_O, DAT_O}, {prev_we, prev_adr, prev_dat});
      end
      if (gap_left > 0) begin
        check("gap_bus_quiet", {STB_O, WE_O, ADR_O, DAT_O}, 37'h0);
        gap_left--;
      end
    end
    if (RST_I) begin
      m_q.delete();
      m_rx_valid = 1'b0;
      m_rx_byte  = 8'h00;
      prev_acc   = 0;
      prev_wait  = 0;
      gap_left   = 0;
      armed      = 1;
    end else if (armed) begin
      acc    = STB_O && ACK_I;
      pop    = acc && WE_O && (ADR_O == OffData);
      accept = tx_push && (m_q.size() < 8 || pop);
      if (acc) acc_log.push_back({WE_O, ADR_O});
      if (acc && WE_O && ADR_O == OffLsr) begin
        n_lsr_wr++;
        check("lsr_clear_data", DAT_O, 32'h0);
      end
      if (pop) begin
        n_data_wr++;
        wr_words.push_back(DAT_O);
        gap_left = TxGap;
        if (m_q.size() == 0) begin
          check("write_from_empty_fifo", m_q.size(), 1);
        end else begin
          check("tx_write_data", DAT_O, {24'h0, m_q[0]});
          void'(m_q.pop_front());
        end
      end
      if (accept) m_q.push_back(tx_byte);
      if (acc && !WE_O && ADR_O == OffData) begin
        n_data_rd++;
`ifdef UART_BUS_MASTER_RX_EN
        check("rx_read_while_valid", m_rx_valid, 1'b0);
        m_rx_valid = 1'b1;
        m_rx_byte  = DAT_I[7:0];
`endif
      end else if (rx_pop) begin
        m_rx_valid = 1'b0;
      end
      prev_acc  = acc;
      prev_wait = STB_O && !ACK_I;
      prev_we   = WE_O;
      prev_adr  = ADR_O;
      prev_dat  = DAT_O;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int get_cnt(input int sel);
    case (sel)
      CntDataWr: return n_data_wr;
      CntDataRd: return n_data_rd;
      default:   return n_lsr_wr;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int sel, input int target, input int budget);
    int k = 0;
    while (get_cnt(sel) < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, get_cnt(sel) >= target, 1'b1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #1;
    tx_push = 1'b1;
    tx_byte = b;
    @(posedge clk);
    #1;
    tx_push = 1'b0;
  endtask

  int base_wr, base_rd, base_lw, base_log, low, rd_idx, wr_idx, k;

  initial begin
    RST_I    = 1'b1;
    ACK_I    = 1'b0;
    DAT_I    = 32'h0;
    tx_push  = 1'b0;
    tx_byte  = 8'h00;
    rx_pop   = 1'b0;
    lsr_reg  = 32'h0;
    data_reg = 32'h0;
    stall_n  = 0;

    // Reset: two cycles, then the first LSR read right after release.
    repeat (2) @(posedge clk);
    #1;
    check("reset_stb", STB_O, 1'b0);
    check("reset_tx_full", tx_full, 1'b0);
    check("reset_rx_valid", rx_valid, 1'b0);
    RST_I = 1'b0;
    @(posedge clk);
    #1;
    check("first_poll_stb", STB_O, 1'b1);
    check("first_poll_adr", ADR_O, OffLsr);
    check("first_poll_we", WE_O, 1'b0);

    // TX: one byte with transmit ready.
    lsr_reg = 32'h20;
    base_wr = n_data_wr;
    push(8'h41);
    wait_cnt("tx_write_seen", CntDataWr, base_wr + 1, 100);
    check("tx_write_word", wr_words[base_wr], 32'h41);
    low = 0;
    while (STB_O === 1'b0 && low < 50) begin
      low++;
      @(posedge clk);
      #1;
    end
    check("tx_gap_low_cycles", low >= TxGap, 1'b1);
    cycles(20);
    check("tx_single_write", n_data_wr, base_wr + 1);
    lsr_reg = 32'h0;

`ifdef UART_BUS_MASTER_RX_EN
    // RX: capture, LSR clear, no re-read while the byte is held.
    base_rd  = n_data_rd;
    base_lw  = n_lsr_wr;
    data_reg = 32'h5A;
    lsr_reg  = 32'h01;
    wait_cnt("rx_read_seen", CntDataRd, base_rd + 1, 100);
    wait_cnt("rx_lsr_clear_seen", CntLsrWr, base_lw + 1, 100);
    check("rx_byte_5a", rx_byte, 8'h5A);
    check("rx_valid_set", rx_valid, 1'b1);
    lsr_reg = 32'h01;
    cycles(30);
    check("rx_no_reread_while_valid", n_data_rd, base_rd + 1);
    data_reg = 32'h33;
    rx_pop   = 1'b1;
    @(posedge clk);
    #1;
    rx_pop = 1'b0;
    check("rx_pop_clears", rx_valid, 1'b0);
    wait_cnt("rx_second_read", CntDataRd, base_rd + 2, 100);
    wait_cnt("rx_second_clear", CntLsrWr, base_lw + 2, 100);
    check("rx_byte_33", rx_byte, 8'h33);
    rx_pop = 1'b1;
    @(posedge clk);
    #1;
    rx_pop = 1'b0;
    lsr_reg = 32'h0;
`else
    // RX disabled: rs is ignored entirely.
    base_rd  = n_data_rd;
    data_reg = 32'h5A;
    lsr_reg  = 32'h01;
    cycles(40);
    check("norx_no_data_read", n_data_rd, base_rd);
    check("norx_rx_valid", rx_valid, 1'b0);
    rx_pop = 1'b1;
    @(posedge clk);
    #1;
    rx_pop = 1'b0;
    check("norx_rx_byte", rx_byte, 8'h00);
    lsr_reg = 32'h0;
`endif

    // Full: nine pushes with ts=0, then push-on-pop while full, then drain.
    cycles(5);
    base_wr = n_data_wr;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (i == 8) check("not_full_at_7", tx_full, 1'b0);
      if (i == 9) check("full_at_8", tx_full, 1'b1);
      tx_push = 1'b1;
      tx_byte = 8'(i);
    end
    @(posedge clk);
    #1;
    check("full_after_drop", tx_full, 1'b1);
    tx_byte = 8'hAA;
    lsr_reg = 32'h20;
    k = 0;
    while (n_data_wr < base_wr + 1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    tx_push = 1'b0;
    check("push_pop_full_keeps_full", tx_full, 1'b1);
    wait_cnt("drain_nine", CntDataWr, base_wr + 9, 400);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", wr_words[base_wr + i], 32'(i + 1));
    end
    check("drain_last_aa", wr_words[base_wr + 8], 32'hAA);
    cycles(30);
    check("drain_no_ninth_byte", n_data_wr, base_wr + 9);
    check("drain_empty_not_full", tx_full, 1'b0);
    lsr_reg = 32'h0;

    // Priority and stall: rs and ts together with a queued byte, slave stalls 5 cycles.
    base_log = acc_log.size();
    base_rd  = n_data_rd;
    base_wr  = n_data_wr;
    push(8'h77);
    data_reg = 32'h99;
    stall_n  = 5;
    lsr_reg  = 32'h21;
    k = 0;
    while (!(STB_O === 1'b1 && WE_O === 1'b1 && ADR_O == OffData) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("stall_write_found", k < 300, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("stall_stb", STB_O, 1'b1);
      check("stall_we", WE_O, 1'b1);
      check("stall_adr", ADR_O, OffData);
      check("stall_dat", DAT_O, 32'h77);
      @(posedge clk);
      #1;
    end
    wait_cnt("prio_write_done", CntDataWr, base_wr + 1, 100);
    rd_idx = -1;
    wr_idx = -1;
    for (int i = base_log; i < acc_log.size(); i++) begin
      if (rd_idx < 0 && acc_log[i] == {1'b0, OffData}) rd_idx = i;
      if (wr_idx < 0 && acc_log[i] == {1'b1, OffData}) wr_idx = i;
    end
`ifdef UART_BUS_MASTER_RX_EN
    check("rx_before_tx", (rd_idx >= 0) && (rd_idx < wr_idx), 1'b1);
    check("prio_rx_byte", rx_byte, 8'h99);
    rx_pop = 1'b1;
    @(posedge clk);
    #1;
    rx_pop = 1'b0;
`else
    check("norx_prio_no_read", n_data_rd, base_rd);
`endif
    stall_n = 0;
    lsr_reg = 32'h0;

    // Reset in the middle of a stalled write abandons it and empties the FIFO.
    cycles(5);
    lsr_reg = 32'h20;
    stall_n = 20;
    push(8'h10);
    push(8'h11);
    k = 0;
    while (!(STB_O === 1'b1 && WE_O === 1'b1) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("midreset_write_found", k < 100, 1'b1);
    RST_I = 1'b1;
    @(posedge clk);
    #1;
    RST_I = 1'b0;
    check("midreset_stb", STB_O, 1'b0);
    check("midreset_we", WE_O, 1'b0);
    check("midreset_tx_full", tx_full, 1'b0);
    stall_n = 0;
    base_wr = n_data_wr;
    cycles(30);
    check("midreset_no_write", n_data_wr, base_wr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
